// File: rtl/moore_rr_arbiter.sv
// moore_rr_arbiter
//   Round-robin arbiter that hands one shared sequencing resource to one of N
//   requesters at a time. It is a Moore machine: every output comes straight
//   from a flop. Each tenure is capped at MAX_HOLD cycles, and one COOLDOWN
//   cycle always separates two tenures.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no owner; arbitrate among pending requests from ptr onward
//   GRANT    | grant_id owns the resource; hold_cnt counts tenure cycles
//   COOLDOWN | grant low for one cycle; expired flags a forced release
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   req       request vector; bit i set = requester i wants the resource
//   grant     registered one-hot grant; all-zero when nobody owns it
//   grant_id  index of the current/last owner; holds its value while idle
//   state_o   00 = IDLE, 01 = GRANT, 10 = COOLDOWN
//   expired   one-cycle pulse in COOLDOWN after a tenure hit MAX_HOLD

module moore_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic [1:0]    state_o,
  output logic          expired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_COOL  = 2'b10
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [7:0]    hold_cnt;

  logic [2*N-1:0] req_rot;
  logic [IW-1:0]  pick_off;
  logic [IW:0]    pick_sum;
  logic [IW-1:0]  pick_id;
  logic           pick_valid;
  logic [IW-1:0]  next_ptr;
  logic           owner_req;
  logic           at_cap;

  // Rotate the request vector so that bit 0 is the requester at ptr; the
  // first set bit of the low N bits is then the winner's distance from ptr.
  assign req_rot = {req, req} >> ptr;

  always_comb begin
    pick_valid = 1'b0;
    pick_off   = '0;
    // Walking downwards lets the requester closest to ptr overwrite the rest.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_valid = 1'b1;
        pick_off   = IW'(i);
      end
    end
    pick_sum = {1'b0, ptr} + {1'b0, pick_off};
    if (pick_sum >= (IW + 1)'(N)) begin
      pick_sum = pick_sum - (IW + 1)'(N);
    end
    pick_id = pick_sum[IW-1:0];
  end

  assign next_ptr  = (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);
  assign owner_req = req[grant_id];
  assign at_cap    = (hold_cnt == 8'(MAX_HOLD));
  assign state_o   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      grant    <= '0;
      grant_id <= '0;
      expired  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          expired <= 1'b0;
          if (pick_valid) begin
            state    <= S_GRANT;
            grant    <= N'(1) << pick_id;
            grant_id <= pick_id;
            hold_cnt <= 8'd1;
          end
        end

        S_GRANT: begin
          // A voluntary drop wins over the cap, so expired stays low then.
          if (!owner_req) begin
            state   <= S_COOL;
            grant   <= '0;
            expired <= 1'b0;
            ptr     <= next_ptr;
          end else if (at_cap) begin
            state   <= S_COOL;
            grant   <= '0;
            expired <= 1'b1;
            ptr     <= next_ptr;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        S_COOL: begin
          state   <= S_IDLE;
          expired <= 1'b0;
        end

        default: begin
          state   <= S_IDLE;
          grant   <= '0;
          expired <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the arbiter.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant));

  a_grant_iff_state : assert property (@(posedge clk) disable iff (reset)
    ((grant != '0) == (state == S_GRANT)));

  a_hold_bounded : assert property (@(posedge clk) disable iff (reset)
    (hold_cnt <= 8'(MAX_HOLD)));

  a_ptr_range : assert property (@(posedge clk) disable iff (reset)
    (int'(ptr) < N));

endmodule

// File: tb/tb_moore_rr_arbiter.sv
// Bench for moore_rr_arbiter: two instances share clk/reset/req, one with the
// default MAX_HOLD=8 and one with MAX_HOLD=3. A tenure-level model tracks each
// instance and is compared on every falling edge; directed sequences add
// literal expectations that pin the model.

module tb_moore_rr_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;

  logic [N-1:0]  gnt_a, gnt_b;
  logic [IW-1:0] gid_a, gid_b;
  logic [1:0]    st_a, st_b;
  logic          exp_a, exp_b;

  always #5 clk = ~clk;

  moore_rr_arbiter #(.N(N), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .grant(gnt_a), .grant_id(gid_a), .state_o(st_a), .expired(exp_a)
  );

  moore_rr_arbiter #(.N(N), .MAX_HOLD(3)) dut_cap (
    .clk(clk), .reset(reset), .req(req),
    .grant(gnt_b), .grant_id(gid_b), .state_o(st_b), .expired(exp_b)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_on    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Tenure-level model: phase 0 idle, 1 owned, 2 cooldown.
  int m_phase [2] = '{0, 0};
  int m_owner [2] = '{0, 0};
  int m_len   [2] = '{0, 0};
  int m_ptr   [2] = '{0, 0};
  bit m_exp   [2] = '{0, 0};
  int m_cap   [2] = '{8, 3};

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        m_phase[u] = 0; m_owner[u] = 0; m_len[u] = 0; m_ptr[u] = 0; m_exp[u] = 0;
      end else if (m_phase[u] == 0) begin
        m_exp[u] = 0;
        if (req != '0) begin
          int best_d;
          best_d = N;
          for (int j = 0; j < N; j++) begin
            int d;
            d = (j - m_ptr[u] + N) % N;
            if (req[j] && d < best_d) begin
              best_d = d;
              m_owner[u] = j;
            end
          end
          m_phase[u] = 1;
          m_len[u] = 1;
        end
      end else if (m_phase[u] == 1) begin
        if (!req[m_owner[u]] || m_len[u] == m_cap[u]) begin
          m_exp[u]   = req[m_owner[u]];
          m_phase[u] = 2;
          m_ptr[u]   = (m_owner[u] + 1) % N;
        end else begin
          m_len[u]++;
        end
      end else begin
        m_phase[u] = 0;
        m_exp[u]   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int u = 0; u < 2; u++) begin
        logic [N-1:0]  g_act;
        logic [IW-1:0] id_act;
        logic [1:0]    s_act;
        logic          e_act;
        logic [N-1:0]  g_exp;
        g_act  = (u == 0) ? gnt_a : gnt_b;
        id_act = (u == 0) ? gid_a : gid_b;
        s_act  = (u == 0) ? st_a  : st_b;
        e_act  = (u == 0) ? exp_a : exp_b;
        g_exp  = (m_phase[u] == 1) ? N'(1 << m_owner[u]) : '0;
        chk($sformatf("model_grant[%0d]", u), 32'(g_act), 32'(g_exp));
        chk($sformatf("model_grant_id[%0d]", u), 32'(id_act), 32'(m_owner[u]));
        chk($sformatf("model_state[%0d]", u), 32'(s_act), 32'(m_phase[u]));
        chk($sformatf("model_expired[%0d]", u), 32'(e_act), 32'(m_exp[u]));
      end
    end
  end

  // Advance one clock; returns 1 time unit after the edge so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] rot_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    reset = 1'b1;
    req   = 4'b1111;

    // Reset held two cycles with all requests high.
    step();
    chk_on = 1'b1;
    step();
    chk("rst_grant", 32'(gnt_a), 32'h0);
    chk("rst_state", 32'(st_a), 32'h0);
    chk("rst_expired", 32'(exp_a), 32'h0);
    chk("rst_grant_id", 32'(gid_a), 32'h0);
    reset = 1'b0;
    step();
    chk("first_grant", 32'(gnt_a), 32'b0001);

    // Rotation: each owner drops after two grant cycles and re-requests in COOLDOWN.
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % N;
      chk($sformatf("rot_grant_%0d", k), 32'(gnt_a), 32'(rot_exp[k]));
      chk($sformatf("rot_state_%0d", k), 32'(st_a), 32'h1);
      step();
      chk($sformatf("rot_hold_%0d", k), 32'(gnt_a), 32'(rot_exp[k]));
      req[g] = 1'b0;
      step();
      chk($sformatf("rot_cool_state_%0d", k), 32'(st_a), 32'h2);
      chk($sformatf("rot_cool_grant_%0d", k), 32'(gnt_a), 32'h0);
      chk($sformatf("rot_cool_exp_%0d", k), 32'(exp_a), 32'h0);
      req[g] = 1'b1;
      step();
      chk($sformatf("rot_idle_%0d", k), 32'(st_a), 32'h0);
      step();
    end

    // Cap on the MAX_HOLD=3 instance with requester 2 held.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("cap_grant_%0d", c), 32'(gnt_b), 32'b0100);
    end
    step();
    chk("cap_cool_state", 32'(st_b), 32'h2);
    chk("cap_cool_expired", 32'(exp_b), 32'h1);
    chk("cap_cool_grant", 32'(gnt_b), 32'h0);
    step();
    chk("cap_idle_state", 32'(st_b), 32'h0);
    chk("cap_idle_expired", 32'(exp_b), 32'h0);
    step();
    chk("cap_regrant", 32'(gnt_b), 32'b0100);

    // Tie: owner drops on the cycle the count reaches the cap.
    step();
    step();
    chk("tie_last_cycle", 32'(gnt_b), 32'b0100);
    req = 4'b0000;
    step();
    chk("tie_state", 32'(st_b), 32'h2);
    chk("tie_expired", 32'(exp_b), 32'h0);

    // Wrap and skip: after granting 2, pointer is 3; req=0011 must wrap to 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b0100;
    step();
    chk("wrap_pre_grant", 32'(gnt_a), 32'b0100);
    req = 4'b0000;
    step();
    req = 4'b0011;
    step();
    step();
    chk("wrap_grant", 32'(gnt_a), 32'b0001);
    chk("wrap_grant_id", 32'(gid_a), 32'h0);

    // Mid-tenure reset during the second grant cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b0100;
    step();
    step();
    chk("mid_second_cycle", 32'(gnt_a), 32'b0100);
    reset = 1'b1;
    step();
    chk("mid_rst_grant", 32'(gnt_a), 32'h0);
    chk("mid_rst_state", 32'(st_a), 32'h0);
    reset = 1'b0;
    req   = 4'b1010;
    step();
    chk("mid_after_grant", 32'(gnt_a), 32'b0010);
    chk("mid_after_id", 32'(gid_a), 32'h1);

    // Randomized traffic with sparse resets, checked by the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) req = '0;
      else req = req ^ (4'($urandom) & 4'($urandom));
    end
    reset = 1'b0;
    req   = '0;
    step();
    step();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
